sipo_mc: RTL

Multi-channel serial-in/parallel-out capture block with an AXI4-Lite slave register interface, all on one clock. CHANNELS serial lanes share a common sample strobe. Each lane deserialises WIDTH-bit words, MSB- or LSB-first, into its own DEPTH-entry FIFO, which software drains over AXI4-Lite. On overflow the block drops the word and keeps word alignment, with a sticky per-lane flag; it does not stall.

---
 rtl/sipo_mc.sv | 361 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sipo_mc.sv
// -----------------------------------------------------------------------------
// sipo_mc : multi-channel serial-in / parallel-out capture block.
//
// CHANNELS serial lanes share one sample strobe (sin_valid). Each lane
// deserialises WIDTH-bit words, LSB- or MSB-first, into its own DEPTH-entry
// FIFO. Software drains the FIFOs through an AXI4-Lite slave. A word that
// arrives at a full FIFO is dropped (the bit counter still wraps, so the
// stream stays word aligned) and a sticky per-lane overflow flag is raised.
//
// Register map (offset from BASE_ADDR, 256-byte window):
//   0x00        CTRL     RW  [0] en, [1] msb_first, [2] clear (action, reads 0)
//   0x04        STATUS   RO  [c] nonempty, [8+c] full, [16+c] overflow
//   0x08        OVF_CLR  W1C [c] clears overflow[c]
//   0x10 + 8c   DATA_c   RO  pops lane c (SLVERR and 0 when empty)
//   0x14 + 8c   LEVEL_c  RO  fill count
//
// Ports:
//   clk, rst              sole clock; asynchronous active-high reset
//   sin[CHANNELS-1:0]     serial data, one bit per lane
//   sin_valid             sample strobe common to all lanes
//   s_axi4lite_*          AXI4-Lite slave (AW, W, B, AR, R channels)
// -----------------------------------------------------------------------------
module sipo_mc #(
  parameter int AXI4_ADDR_BITS = 32,
  parameter int AXI4_DATA_BITS = 32,
  parameter int AXI4_STRB_BITS = AXI4_DATA_BITS / 8,
  parameter int AXI4_PROT_BITS = 3,
  parameter int AXI4_RESP_BITS = 2,
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 16,
  parameter logic [AXI4_ADDR_BITS-1:0] BASE_ADDR = 'h0000_1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       sin,
  input  logic                      sin_valid,
  output logic                      s_axi4lite_aw_ready,
  input  logic                      s_axi4lite_aw_valid,
  input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_aw_addr,
  input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_aw_prot,
  output logic                      s_axi4lite_w_ready,
  input  logic                      s_axi4lite_w_valid,
  input  logic [AXI4_DATA_BITS-1:0] s_axi4lite_w_data,
  input  logic [AXI4_STRB_BITS-1:0] s_axi4lite_w_strb,
  input  logic                      s_axi4lite_b_ready,
  output logic                      s_axi4lite_b_valid,
  output logic [AXI4_RESP_BITS-1:0] s_axi4lite_b_resp,
  output logic                      s_axi4lite_ar_ready,
  input  logic                      s_axi4lite_ar_valid,
  input  logic [AXI4_ADDR_BITS-1:0] s_axi4lite_ar_addr,
  input  logic [AXI4_PROT_BITS-1:0] s_axi4lite_ar_prot,
  input  logic                      s_axi4lite_r_ready,
  output logic                      s_axi4lite_r_valid,
  output logic [AXI4_DATA_BITS-1:0] s_axi4lite_r_data,
  output logic [AXI4_RESP_BITS-1:0] s_axi4lite_r_resp
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [AXI4_RESP_BITS-1:0] RESP_OKAY   = '0;
  localparam logic [AXI4_RESP_BITS-1:0] RESP_SLVERR = AXI4_RESP_BITS'(2);

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_STATUS,
    REG_OVF_CLR,
    REG_DATA,
    REG_LEVEL
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] lane;
  } reg_sel_t;

  // Map a bus address onto a register kind and lane. Anything outside the
  // window, misaligned, or naming a lane that does not exist is REG_NONE.
  function automatic reg_sel_t decode(input logic [AXI4_ADDR_BITS-1:0] addr);
    reg_sel_t   sel;
    logic [7:0] off;
    logic [4:0] idx;
    sel.kind = REG_NONE;
    sel.lane = '0;
    off      = addr[7:0];
    idx      = off[7:3] - 5'd2;
    if (addr[AXI4_ADDR_BITS-1:8] == BASE_ADDR[AXI4_ADDR_BITS-1:8]) begin
      if (off == 8'h00) begin
        sel.kind = REG_CTRL;
      end else if (off == 8'h04) begin
        sel.kind = REG_STATUS;
      end else if (off == 8'h08) begin
        sel.kind = REG_OVF_CLR;
      end else if (off >= 8'h10 && off[1:0] == 2'b00 && idx < 5'(CHANNELS)) begin
        sel.kind = off[2] ? REG_LEVEL : REG_DATA;
        sel.lane = idx[2:0];
      end
    end
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                      aw_held_q, w_held_q, ar_held_q;
  logic [AXI4_ADDR_BITS-1:0] aw_addr_q, ar_addr_q;
  logic [AXI4_DATA_BITS-1:0] w_data_q;
  logic                      b_valid_q, r_valid_q;
  logic [AXI4_RESP_BITS-1:0] b_resp_q, r_resp_q;
  logic [AXI4_DATA_BITS-1:0] r_data_q;

  logic                      en_q, en_d;
  logic                      msb_first_q, msb_first_d;
  logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]          shift_q [CHANNELS];
  logic [WIDTH-1:0]          shift_d [CHANNELS];
  logic [WIDTH-1:0]          shifted [CHANNELS];

  logic [WIDTH-1:0]          mem_q    [CHANNELS][DEPTH];
  logic [PW-1:0]             wr_ptr_q [CHANNELS];
  logic [PW-1:0]             wr_ptr_d [CHANNELS];
  logic [PW-1:0]             rd_ptr_q [CHANNELS];
  logic [PW-1:0]             rd_ptr_d [CHANNELS];
  logic [LW-1:0]             level_q  [CHANNELS];
  logic [LW-1:0]             level_d  [CHANNELS];
  logic [CHANNELS-1:0]       ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // AXI handshake and commit decode
  // ---------------------------------------------------------------------------
  reg_sel_t            wr_sel, rd_sel;
  logic                wr_commit, rd_fire;
  logic                ctrl_wr, clear, msb_change;
  logic [CHANNELS-1:0] ovf_clr_mask;

  assign s_axi4lite_aw_ready = !aw_held_q && !b_valid_q;
  assign s_axi4lite_w_ready  = !w_held_q  && !b_valid_q;
  assign s_axi4lite_ar_ready = !ar_held_q && !r_valid_q;
  assign s_axi4lite_b_valid  = b_valid_q;
  assign s_axi4lite_b_resp   = b_resp_q;
  assign s_axi4lite_r_valid  = r_valid_q;
  assign s_axi4lite_r_data   = r_data_q;
  assign s_axi4lite_r_resp   = r_resp_q;

  assign wr_sel       = decode(aw_addr_q);
  assign rd_sel       = decode(ar_addr_q);
  assign wr_commit    = aw_held_q && w_held_q && !b_valid_q;
  assign rd_fire      = ar_held_q && !r_valid_q;
  assign ctrl_wr      = wr_commit && (wr_sel.kind == REG_CTRL);
  assign clear        = ctrl_wr && w_data_q[2];
  assign msb_change   = ctrl_wr && (w_data_q[1] != msb_first_q);
  assign ovf_clr_mask = (wr_commit && wr_sel.kind == REG_OVF_CLR) ?
                        w_data_q[CHANNELS-1:0] : '0;

  // Protection, byte strobes and the upper write-data bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot,
                           s_axi4lite_w_strb, w_data_q};

  // ---------------------------------------------------------------------------
  // Deserialiser
  // ---------------------------------------------------------------------------
  logic strobe, wrap;

  assign strobe = en_q && sin_valid;
  assign wrap   = strobe && (bit_cnt_q == CW'(WIDTH - 1));

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    for (int c = 0; c < CHANNELS; c++) begin
      // LSB-first enters at the top and walks down, so the first bit ends in
      // bit 0; MSB-first enters at the bottom and ends in bit WIDTH-1.
      shifted[c] = msb_first_q ? {shift_q[c][WIDTH-2:0], sin[c]}
                               : {sin[c], shift_q[c][WIDTH-1:1]};
      shift_d[c] = shift_q[c];
    end
    if (clear || msb_change) begin
      bit_cnt_d = '0;
      for (int c = 0; c < CHANNELS; c++) shift_d[c] = '0;
    end else if (strobe) begin
      bit_cnt_d = wrap ? '0 : bit_cnt_q + CW'(1);
      for (int c = 0; c < CHANNELS; c++) shift_d[c] = wrap ? '0 : shifted[c];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] nonempty, full, pop, push_ok, ovf_set;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      nonempty[c] = (level_q[c] != '0);
      full[c]     = (level_q[c] == LW'(DEPTH));
      pop[c]      = rd_fire && (rd_sel.kind == REG_DATA) &&
                    (int'(rd_sel.lane) == c) && nonempty[c];
      // A pop on the same edge frees the slot the push needs.
      push_ok[c]  = wrap && (!full[c] || pop[c]);
      ovf_set[c]  = wrap && full[c] && !pop[c];

      wr_ptr_d[c] = wr_ptr_q[c] + PW'(push_ok[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop[c]);
      level_d[c]  = level_q[c] + LW'(push_ok[c]) - LW'(pop[c]);
      if (clear) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        level_d[c]  = '0;
      end
    end
    ovf_d = clear ? '0 : ((ovf_q & ~ovf_clr_mask) | ovf_set);
  end

  // ---------------------------------------------------------------------------
  // Control register and read-data mux
  // ---------------------------------------------------------------------------
  logic [AXI4_DATA_BITS-1:0] rd_data;
  logic [AXI4_RESP_BITS-1:0] rd_resp;

  always_comb begin
    en_d        = en_q;
    msb_first_d = msb_first_q;
    if (ctrl_wr) begin
      en_d        = w_data_q[0];
      msb_first_d = w_data_q[1];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    unique case (rd_sel.kind)
      REG_CTRL:    rd_data[1:0] = {msb_first_q, en_q};
      REG_STATUS: begin
        for (int c = 0; c < CHANNELS; c++) begin
          rd_data[c]      = nonempty[c];
          rd_data[8 + c]  = full[c];
          rd_data[16 + c] = ovf_q[c];
        end
      end
      REG_OVF_CLR: rd_data = '0;
      REG_DATA: begin
        rd_resp = RESP_SLVERR;
        for (int c = 0; c < CHANNELS; c++) begin
          if (int'(rd_sel.lane) == c && nonempty[c]) begin
            rd_data[WIDTH-1:0] = mem_q[c][rd_ptr_q[c]];
            rd_resp            = RESP_OKAY;
          end
        end
      end
      REG_LEVEL: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (int'(rd_sel.lane) == c) rd_data[LW-1:0] = level_q[c];
        end
      end
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q        <= 1'b1;
      msb_first_q <= 1'b0;
      bit_cnt_q   <= '0;
      ovf_q       <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        shift_q[c]  <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        level_q[c]  <= '0;
      end
    end else begin
      en_q        <= en_d;
      msb_first_q <= msb_first_d;
      bit_cnt_q   <= bit_cnt_d;
      ovf_q       <= ovf_d;
      for (int c = 0; c < CHANNELS; c++) begin
        shift_q[c]  <= shift_d[c];
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        level_q[c]  <= level_d[c];
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the level and pointers alone
  // decide which entries are valid, and leaving the array unreset lets it map
  // onto plain RAM.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push_ok[c]) mem_q[c][wr_ptr_q[c]] <= shifted[c];
    end
  end

  // Write channel: AW and W are captured independently and committed together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= '0;
    end else begin
      if (s_axi4lite_aw_valid && s_axi4lite_aw_ready) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= s_axi4lite_aw_addr;
      end else if (wr_commit) begin
        aw_held_q <= 1'b0;
      end
      if (s_axi4lite_w_valid && s_axi4lite_w_ready) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axi4lite_w_data;
      end else if (wr_commit) begin
        w_held_q <= 1'b0;
      end
      if (wr_commit) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= (wr_sel.kind == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi4lite_b_ready) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  // Read channel: data is registered on the edge after the AR handshake and
  // held until the master accepts it; a DATA pop happens on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_held_q <= 1'b0;
      ar_addr_q <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
    end else begin
      if (s_axi4lite_ar_valid && s_axi4lite_ar_ready) begin
        ar_held_q <= 1'b1;
        ar_addr_q <= s_axi4lite_ar_addr;
      end else if (rd_fire) begin
        ar_held_q <= 1'b0;
      end
      if (rd_fire) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_data;
        r_resp_q  <= rd_resp;
      end else if (s_axi4lite_r_ready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

endmodule
